// File: rtl/add_type_pkg.sv
// Shared data types used as DTYPE overrides when instantiating add_type.
package add_type_pkg;

  typedef logic signed [23:0] bus24_t;
  typedef real                add_real_t;

endpackage

// File: rtl/add_type.sv
// Type-parameterized registered adder: sum <= a + b one cycle after sampling.
// No enable or handshake; reset clears sum asynchronously.
module add_type #(
  parameter type DTYPE = logic
) (
  input  logic clk,
  input  logic rst,
  input  DTYPE a,
  input  DTYPE b,
  output DTYPE sum
);

  // Integral sums truncate to the width of DTYPE, so overflow wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sum <= DTYPE'(0);
    else     sum <= a + b;
  end

endmodule

// File: tb/tb_add_type.sv
// Directed bench: four add_type configurations driven in lockstep from one vector table.
module tb_add_type;
  import add_type_pkg::*;

  logic      clk = 1'b0;
  logic      rst = 1'b0;

  logic      l_a = 1'b0, l_b = 1'b0, l_sum;
  int        i_a = 0,    i_b = 0,    i_sum;
  bus24_t    b_a = '0,   b_b = '0,   b_sum;
  add_real_t r_a = 0.0,  r_b = 0.0,  r_sum;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  add_type #(.DTYPE(logic))      u_logic (.clk(clk), .rst(rst), .a(l_a), .b(l_b), .sum(l_sum));
  add_type #(.DTYPE(int))        u_int   (.clk(clk), .rst(rst), .a(i_a), .b(i_b), .sum(i_sum));
  add_type #(.DTYPE(bus24_t))    u_bus   (.clk(clk), .rst(rst), .a(b_a), .b(b_b), .sum(b_sum));
  add_type #(.DTYPE(add_real_t)) u_real  (.clk(clk), .rst(rst), .a(r_a), .b(r_b), .sum(r_sum));

  typedef struct {
    logic      la, lb, lexp;
    int        ia, ib, iexp;
    bus24_t    ba, bb, bexp;
    add_real_t ra, rb, rexp;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_r(input string name, input real act, input real exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %f expected %f", name, act, exp);
    end
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{la:1'b1, lb:1'b0, lexp:1'b1,
                ia:100, ib:-250, iexp:-150,
                ba:24'sh7FFFFF, bb:24'sd1, bexp:24'sh800000,
                ra:1.25, rb:-3.5, rexp:-2.25};
    vecs[1] = '{la:1'b1, lb:1'b1, lexp:1'b0,
                ia:32'h7FFFFFFF, ib:1, iexp:32'h80000000,
                ba:-24'sd5, bb:-24'sd7, bexp:-24'sd12,
                ra:0.5, rb:0.25, rexp:0.75};
    vecs[2] = '{la:1'b0, lb:1'b1, lexp:1'b1,
                ia:-1, ib:-1, iexp:-2,
                ba:24'shFFFFFF, bb:24'sd1, bexp:24'sd0,
                ra:-1.0, rb:1.0, rexp:0.0};
    vecs[3] = '{la:1'b0, lb:1'b0, lexp:1'b0,
                ia:12345, ib:54321, iexp:66666,
                ba:24'sh800000, bb:24'sh800000, bexp:24'sd0,
                ra:1000.0, rb:2.5, rexp:1002.5};

    // Load non-zero results first so the reset clear is observable.
    l_a = 1'b1; i_a = 7; i_b = 8; b_a = 24'sd3; b_b = 24'sd4; r_a = 2.0; r_b = 0.5;
    edge_wait();
    chk("preload_int", longint'(i_sum), 64'sd15);
    chk_r("preload_real", r_sum, 2.5);

    // Asynchronous reset, checked before any further clock edge.
    #1 rst = 1'b1;
    #1;
    chk("rst_logic", longint'(l_sum), 64'sd0);
    chk("rst_int",   longint'(i_sum), 64'sd0);
    chk("rst_bus24", longint'(b_sum), 64'sd0);
    chk_r("rst_real", r_sum, 0.0);
    edge_wait();
    chk("rst_hold_int", longint'(i_sum), 64'sd0);
    rst = 1'b0;

    for (int k = 0; k < 4; k++) begin
      l_a = vecs[k].la; l_b = vecs[k].lb;
      i_a = vecs[k].ia; i_b = vecs[k].ib;
      b_a = vecs[k].ba; b_b = vecs[k].bb;
      r_a = vecs[k].ra; r_b = vecs[k].rb;
      #1;
      // Output must still show the previous result: no combinational path.
      chk("hold_int", longint'(i_sum), (k == 0) ? 64'sd0 : longint'(vecs[k-1].iexp));
      edge_wait();
      chk("vec_logic", longint'(l_sum), longint'(vecs[k].lexp));
      chk("vec_int",   longint'(i_sum), longint'(vecs[k].iexp));
      chk("vec_bus24", longint'(b_sum), longint'(vecs[k].bexp));
      chk_r("vec_real", r_sum, vecs[k].rexp);
    end

    // Reset mid-operation on the int configuration.
    i_a = 10; i_b = 20;
    repeat (3) edge_wait();
    chk("mid_run_int", longint'(i_sum), 64'sd30);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_int", longint'(i_sum), 64'sd0);
    edge_wait();
    chk("mid_rst_hold_int", longint'(i_sum), 64'sd0);
    #2 rst = 1'b0;
    #1;
    chk("post_rst_no_edge_int", longint'(i_sum), 64'sd0);
    edge_wait();
    chk("post_rst_load_int", longint'(i_sum), 64'sd30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
